// File: rtl/bitscan_encoder_if.sv
// Request-vector in / index-stream out handshake bundle.
// master drives vectors and consumes indices; slave is the encoder.
interface bitscan_encoder_if #(
  parameter int N = 16,
  parameter int W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_vec;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_last;
  logic         out_none;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx,
    input  out_last, out_none
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx,
    output out_last, out_none
  );
endinterface

// File: rtl/bitscan_encoder.sv
// Serialises an N-bit request vector into one index per set bit.
// BITSCAN_MSB_FIRST_EN selects highest-first scan order.
module bitscan_encoder #(
  parameter int N = 16,
  parameter int W = 4
) (
  input logic             clk,
  input logic             reset,
  bitscan_encoder_if.slave bus
);

  if (N < 2 || N > 256 || W != $clog2(N)) begin : g_bad_cfg
    $error("bitscan_encoder: need 2<=N<=256 and W==clog2(N)");
  end

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

  state_e       state_q;
  logic [N-1:0] pending_q;
  logic [N-1:0] pending_d;
  logic         in_ready_q;
  logic         out_valid_q;
  logic [W-1:0] out_idx_q;
  logic         out_last_q;
  logic         out_none_q;

  logic [W-1:0] scan_idx;
  logic         scan_last;
  logic         scan_none;

  // The vector the next output is derived from: a fresh one in IDLE,
  // otherwise the pending set minus the bit being transferred.
  always_comb begin
    if (state_q == IDLE) begin
      pending_d = bus.in_vec;
    end else begin
      pending_d = pending_q & ~(N'(1) << out_idx_q);
    end
  end

  always_comb begin
    scan_idx = '0;
`ifdef BITSCAN_MSB_FIRST_EN
    for (int i = 0; i < N; i++) begin
      if (pending_d[i]) scan_idx = W'(i);
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (pending_d[i]) scan_idx = W'(i);
    end
`endif
  end

  // Zero or a single set bit both clear under v & (v-1).
  assign scan_last = (pending_d & (pending_d - N'(1))) == '0;
  assign scan_none = pending_d == '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_none_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            state_q     <= EMIT;
            pending_q   <= pending_d;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            out_idx_q   <= scan_idx;
            out_last_q  <= scan_last;
            out_none_q  <= scan_none;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            if (out_last_q) begin
              state_q     <= IDLE;
              pending_q   <= '0;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_idx_q   <= '0;
              out_last_q  <= 1'b0;
              out_none_q  <= 1'b0;
            end else begin
              pending_q  <= pending_d;
              out_idx_q  <= scan_idx;
              out_last_q <= scan_last;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_none  = out_none_q;

endmodule

// File: tb/tb_bitscan_encoder.sv
// Scoreboard bench for bitscan_encoder (N=16 and N=8 instances).
// Reference model lists set-bit indices in scan order per vector.
module tb_bitscan_encoder;

  typedef struct {
    int idx;
    bit last;
    bit none;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic rdy_fix;
  logic rand_ready;
  logic rnd_bit;

  int total = 0;
  int bad = 0;

  exp_t q16[$];
  exp_t q8[$];

  bitscan_encoder_if #(.N(16), .W(4)) bus16 ();
  bitscan_encoder_if #(.N(8),  .W(3)) bus8 ();

  bitscan_encoder #(.N(16), .W(4)) dut16 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus16)
  );

  bitscan_encoder #(.N(8), .W(3)) dut8 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  assign bus16.out_ready = rand_ready ? rnd_bit : rdy_fix;
  assign bus8.out_ready  = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream: every set bit once, in scan order; empty -> one "none".
  function automatic void expect_vec(input int n, input logic [15:0] v);
    int   lst[$];
    exp_t e;
    for (int k = 0; k < n; k++) begin
      if (v[k]) begin
`ifdef BITSCAN_MSB_FIRST_EN
        lst.push_front(k);
`else
        lst.push_back(k);
`endif
      end
    end
    if (lst.size() == 0) begin
      e = '{idx: 0, last: 1'b1, none: 1'b1};
      if (n == 8) q8.push_back(e); else q16.push_back(e);
    end
    foreach (lst[i]) begin
      e = '{idx: lst[i], last: (i == lst.size() - 1), none: 1'b0};
      if (n == 8) q8.push_back(e); else q16.push_back(e);
    end
  endfunction

  // Monitor for N=16: pops on transfer, checks hold under backpressure.
  bit   stall;
  exp_t held;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      stall = 1'b0;
    end else begin
      if (bus16.out_valid) chk("in_ready_in_emit", int'(bus16.in_ready), 0);
      if (stall && bus16.out_valid) begin
        chk("hold_idx",  int'(bus16.out_idx),  held.idx);
        chk("hold_last", int'(bus16.out_last), int'(held.last));
        chk("hold_none", int'(bus16.out_none), int'(held.none));
      end
      if (bus16.out_valid && bus16.out_ready) begin
        stall = 1'b0;
        if (q16.size() == 0) begin
          chk("unexpected_out16", 1, 0);
        end else begin
          e = q16.pop_front();
          chk("idx16",  int'(bus16.out_idx),  e.idx);
          chk("last16", int'(bus16.out_last), int'(e.last));
          chk("none16", int'(bus16.out_none), int'(e.none));
        end
      end else if (bus16.out_valid) begin
        stall = 1'b1;
        held  = '{idx: int'(bus16.out_idx), last: bus16.out_last,
                  none: bus16.out_none};
      end else begin
        stall = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus8.out_valid) begin
      if (q8.size() == 0) begin
        chk("unexpected_out8", 1, 0);
      end else begin
        e = q8.pop_front();
        chk("idx8",  int'(bus8.out_idx),  e.idx);
        chk("last8", int'(bus8.out_last), int'(e.last));
        chk("none8", int'(bus8.out_none), int'(e.none));
      end
    end
  end

  task automatic wait_ready16(output int cyc);
    cyc = 0;
    while (!bus16.in_ready && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus16.in_ready) chk("timeout_in_ready16", 0, 1);
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send16(input logic [15:0] v);
    int c;
    wait_ready16(c);
    bus16.in_valid = 1'b1;
    bus16.in_vec   = v;
    expect_vec(16, v);
    @(posedge clk);
    #1 bus16.in_valid = 1'b0;
    @(negedge clk);
    chk("latency_valid16", int'(bus16.out_valid), 1);
  endtask

  task automatic send8(input logic [7:0] v);
    int c = 0;
    while (!bus8.in_ready && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (!bus8.in_ready) chk("timeout_in_ready8", 0, 1);
    bus8.in_valid = 1'b1;
    bus8.in_vec   = v;
    expect_vec(8, {8'h00, v});
    @(posedge clk);
    #1 bus8.in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int c;
    logic [15:0] v;
    reset          = 1'b1;
    rdy_fix        = 1'b1;
    rand_ready     = 1'b0;
    bus16.in_valid = 1'b0;
    bus16.in_vec   = '0;
    bus8.in_valid  = 1'b0;
    bus8.in_vec    = '0;

    @(negedge clk);
    chk("rst_in_ready",  int'(bus16.in_ready),  1);
    chk("rst_out_valid", int'(bus16.out_valid), 0);
    chk("rst_out_idx",   int'(bus16.out_idx),   0);
    chk("rst_out_last",  int'(bus16.out_last),  0);
    chk("rst_out_none",  int'(bus16.out_none),  0);
    @(negedge clk);
    reset = 1'b0;

    send16(16'h0001);
    @(negedge clk);
    chk("idle_in_ready", int'(bus16.in_ready),  1);
    chk("idle_valid",    int'(bus16.out_valid), 0);

    send16(16'h8000);
    wait_ready16(c);

    send16(16'hA412);
    wait_ready16(c);
    chk("a412_cycles", c, 5);

    send16(16'h0000);
    wait_ready16(c);
    chk("zero_cycles", c, 1);

    rdy_fix = 1'b0;
    send16(16'h0101);
    repeat (3) @(posedge clk);
    #1 rdy_fix = 1'b1;
    wait_ready16(c);

    send16(16'hFFFF);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_out_valid", int'(bus16.out_valid), 0);
    chk("midrst_in_ready",  int'(bus16.in_ready),  1);
    chk("midrst_out_idx",   int'(bus16.out_idx),   0);
    chk("midrst_left",      q16.size(),            11);
    q16.delete();
    q8.delete();
    @(negedge clk);
    reset = 1'b0;

    send16(16'h0004);
    wait_ready16(c);

    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) v = 16'h0000;
      else if ($urandom_range(0, 5) == 0) v = 16'hFFFF;
      else v = 16'($urandom & $urandom);
      send16(v);
    end
    wait_ready16(c);
    rand_ready = 1'b0;

    send8(8'hC0);
    send8(8'h00);
    for (int i = 0; i < 10; i++) send8(8'($urandom));
    repeat (20) @(negedge clk);

    chk("drain16", q16.size(), 0);
    chk("drain8",  q8.size(),  0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bitscan_encoder.md
Name: bitscan_encoder

Overview:
- Parametrised, sequential successor to the 16:4 one-hot encoder.
- Accepts an N-bit request vector with any number of set bits, not only one-hot.
- Serialises the vector into a stream of binary indices, one per set bit, lowest index first, each with valid/ready handshake.
- Sits between request-collection logic (interrupt/flag registers) and a single consumer that services one index at a time.

Parameters:
- N, 16, input vector width; legal range 2..256.
- W, 4, output index width; must equal ceil(log2(N)); elaboration error otherwise.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream presents in_vec.
- in_ready  output  1  block can accept a new vector.
- in_vec  input  N  request vector; bit k maps to index k.
- out_valid  output  1  out_idx/out_last/out_none are valid.
- out_ready  input  1  downstream accepts the current output.
- out_idx  output  W  binary index of the current set bit.
- out_last  output  1  current output is the final one for this vector.
- out_none  output  1  accepted vector was all-zero; out_idx is 0.

Behaviour:
- Reset (async assert, synchronous-to-clk deassert not required): state=IDLE, pending=0, in_ready=1, out_valid=0, out_idx=0, out_last=0, out_none=0.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - EMIT: in_ready=0, out_valid=1.
- Accept: in_valid & in_ready at an edge.
  - Latch in_vec into pending and go to EMIT.
  - out_valid rises the next cycle: latency 1 cycle.
- All outputs are registered. No combinational path from in_* to out_*, or from out_ready to in_ready.
- In EMIT:
  - out_idx = index of lowest set bit of pending.
  - out_last = 1 iff pending has exactly one set bit.
- Transfer: out_valid & out_ready at an edge.
  - Clear that bit in pending.
  - If out_last: go to IDLE, out_valid=0 next cycle, in_ready=1 next cycle.
  - Else: stay in EMIT and present the next lowest set bit the next cycle.
  - Throughput is 1 index/cycle while out_ready=1.
- Backpressure: while out_valid & !out_ready, out_idx, out_last and out_none hold stable.
- All-zero vector: enter EMIT with out_none=1, out_last=1, out_idx=0. One transfer, then IDLE.
- Full vector (all N bits set): exactly N transfers, indices 0..N-1 in order, out_last only on index N-1.
- No new vector is accepted until the final transfer completes; in_ready is low throughout EMIT.
- Reset mid-EMIT discards pending immediately; outputs return to reset values asynchronously.
- out_idx is zero-extended when N < 2^W. Bits of in_vec beyond N do not exist.

Optional Feature:
- Macro: BITSCAN_MSB_FIRST_EN.
- Defined: scan order is highest set bit first.
  - out_idx = index of highest set bit of pending.
  - out_last is still asserted on the sole remaining bit.
  - All-zero handling is unchanged.
- Undefined: lowest-first order as above.
- Port list is identical in both builds.

Test Plan:
- Reset, then in_vec=16'h0001 accepted with out_ready=1 -> next cycle out_valid=1, out_idx=0, out_last=1, out_none=0; following cycle in_ready=1.
- in_vec=16'h8000 -> single output out_idx=15 (4'b1111), out_last=1.
- in_vec=16'hA412, out_ready=1 -> out_idx sequence 1,4,10,13,15 on consecutive cycles, out_last only with 15; in_ready=0 for those 5 cycles.
  - With BITSCAN_MSB_FIRST_EN: sequence 15,13,10,4,1.
- in_vec=16'h0000 -> one output with out_none=1, out_idx=0, out_last=1; then IDLE.
- in_vec=16'h0101 with out_ready held low 3 cycles -> out_idx=0 stable for 3 cycles; on release, transfers 0 then 8.
- in_vec=16'hFFFF, out_ready=1, assert reset after 5 transfers -> out_valid=0 and in_ready=1 immediately. After reset release, a new vector 16'h0004 yields out_idx=2 only.
- N=8, W=3 instance: in_vec=8'hC0 -> out_idx 6 then 7.
